vector_merge_784: RTL and testbench

Gathers thirteen sequential chunk results (twelve 1x64 chunks plus one 1x16 tail, 16-bit signed elements) back into one 1x784 vector. It is the inverse of the 784-to-64 chunk splitter: the splitter feeds the 1x64 processing elements, and this block packs their results in the same bit order for the next layer. Chunks arrive over a valid/ready handshake. The assembled vector is held and presented over a second valid/ready handshake.

---
 rtl/vector_merge_784.sv | 105 ++++++++++
 tb/tb_vector_merge_784.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_merge_784.sv
// vector_merge_784: packs thirteen chunk results (12 x 1x64 plus a 1x16 tail,
// 16-bit signed elements) back into one 1x784 vector. The bit order matches
// the 784-to-64 chunk splitter. Chunks arrive over a valid/ready handshake,
// and the finished vector is held behind a second valid/ready handshake.
module vector_merge_784 (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic [1023:0]  chunk_in,
  input  logic           chunk_valid,
  output logic           chunk_ready,
  output logic [12543:0] vector,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [3:0]     chunk_cnt,
  output logic           finish
);

  typedef enum logic {
    COLLECT,
    FULL
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [12543:0]  vec_q, vec_d;
  logic            fin_q, fin_d;
  logic            accept;
  logic            last_chunk;

  assign accept     = chunk_valid && chunk_ready;
  assign last_chunk = (cnt_q == 4'd12);

  // State register; asynchronous reset returns to COLLECT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clr wins, the 13th accept fills, the output handshake drains.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: if (accept && last_chunk) state_d = FULL;
        FULL:    if (out_ready)            state_d = COLLECT;
        default: state_d = COLLECT;
      endcase
    end
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    chunk_ready = (state_q == COLLECT);
    out_valid   = (state_q == FULL);
  end

  // Slot counter, finish pulse and slot write of the assembly buffer.
  always_comb begin
    cnt_d = cnt_q;
    fin_d = 1'b0;
    vec_d = vec_q;
    if (clr) begin
      cnt_d = '0;
      vec_d = '0;
    end else if (accept) begin
      if (last_chunk) begin
        // Tail chunk: only the low 16 elements are meaningful.
        vec_d[255:0] = chunk_in[255:0];
        cnt_d        = '0;
        fin_d        = 1'b1;
      end else begin
        for (int unsigned k = 0; k < 12; k++) begin
          if (cnt_q == 4'(k)) begin
            vec_d[12543 - 1024*k -: 1024] = chunk_in;
          end
        end
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Datapath registers; reset discards any partial assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      vec_q <= '0;
      fin_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      vec_q <= vec_d;
      fin_q <= fin_d;
    end
  end

  assign vector    = vec_q;
  assign chunk_cnt = cnt_q;
  assign finish    = fin_q;

endmodule

// File: tb/tb_vector_merge_784.sv
// Self-checking bench for vector_merge_784 against an element-array model.
module tb_vector_merge_784;

  logic           clk;
  logic           rst;
  logic           clr;
  logic [1023:0]  chunk_in;
  logic           chunk_valid;
  logic           chunk_ready;
  logic [12543:0] vector;
  logic           out_valid;
  logic           out_ready;
  logic [3:0]     chunk_cnt;
  logic           finish;

  vector_merge_784 dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .chunk_in    (chunk_in),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .vector      (vector),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .chunk_cnt   (chunk_cnt),
    .finish      (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 784 elements, a slot counter, a full flag, a finish flag.
  logic [15:0] m_elem [784];
  int          m_cnt;
  bit          m_full;
  bit          m_fin;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [12543:0] obs, input logic [12543:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      int w;
      n_err++;
      w = 0;
      for (int e = 0; e < 784; e++) begin
        if (obs[12543-16*e -: 16] !== exp[12543-16*e -: 16]) begin
          w = e;
          break;
        end
      end
      $display("FAIL %s @%0t: word %0d got %h expected %h", tag, $time, w,
               obs[12543-16*w -: 16], exp[12543-16*w -: 16]);
    end
  endtask

  function automatic logic [12543:0] model_vector();
    logic [12543:0] v;
    for (int e = 0; e < 784; e++) v[12543-16*e -: 16] = m_elem[e];
    return v;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < 784; e++) m_elem[e] = '0;
    m_cnt  = 0;
    m_full = 0;
    m_fin  = 0;
  endtask

  task automatic check_all();
    chk("chunk_ready", 12544'(chunk_ready), 12544'(!m_full));
    chk("out_valid",   12544'(out_valid),   12544'(m_full));
    chk("finish",      12544'(finish),      12544'(m_fin));
    chk("chunk_cnt",   12544'(chunk_cnt),   12544'(m_cnt));
    chk("vector",      vector,              model_vector());
  endtask

  // One clock: drive inputs, advance the model, check 1 time unit after the edge.
  task automatic step(input logic v, input logic [1023:0] d, input logic ordy, input logic c);
    chunk_valid = v;
    chunk_in    = d;
    out_ready   = ordy;
    clr         = c;
    if (rst) begin
      m_fin = 0;
      if (c) begin
        model_reset();
      end else if (!m_full && v) begin
        if (m_cnt == 12) begin
          for (int j = 0; j < 16; j++) m_elem[768+j] = d[255-16*j -: 16];
          m_cnt  = 0;
          m_full = 1;
          m_fin  = 1;
        end else begin
          for (int j = 0; j < 64; j++) m_elem[64*m_cnt+j] = d[1023-16*j -: 16];
          m_cnt++;
        end
      end else if (m_full && ordy) begin
        m_full = 0;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [1023:0] fill_chunk(input logic [15:0] val);
    logic [1023:0] d;
    for (int j = 0; j < 64; j++) d[1023-16*j -: 16] = val;
    return d;
  endfunction

  function automatic logic [1023:0] rand_chunk();
    logic [1023:0] d;
    for (int j = 0; j < 64; j++) begin
      case ($urandom_range(0, 3))
        0:       d[1023-16*j -: 16] = 16'h8000;
        1:       d[1023-16*j -: 16] = 16'h7FFF;
        2:       d[1023-16*j -: 16] = 16'hFFFF;
        default: d[1023-16*j -: 16] = 16'($urandom);
      endcase
    end
    return d;
  endfunction

  initial begin
    logic [1023:0] d;
    logic [12543:0] held;
    int guard;

    rst = 1'b0; clr = 1'b0; chunk_valid = 1'b0; out_ready = 1'b0; chunk_in = '0;
    model_reset();
    #12;
    check_all();
    rst = 1'b1;

    // Back-to-back fill, chunk k = all elements k+1; tail has junk in its upper bits.
    for (int k = 0; k < 13; k++) begin
      if (k == 12) begin
        d = '1;
        d[255:0] = {16{16'h000D}};
      end else begin
        d = fill_chunk(16'(k + 1));
      end
      step(1'b1, d, 1'b0, 1'b0);
    end
    chk("first_elem", 12544'(vector[12543:12528]), 12544'(16'd1));
    chk("chunk11",    12544'(vector[1279:1264]),   12544'(16'd12));
    chk("tail",       12544'(vector[255:0]),       12544'({16{16'd13}}));

    // FULL hold with chunks still offered; finish must have dropped.
    held = vector;
    for (int i = 0; i < 5; i++) step(1'b1, rand_chunk(), 1'b0, 1'b0);
    chk("held_vector", vector, held);
    step(1'b1, rand_chunk(), 1'b1, 1'b0);
    d = fill_chunk(16'hA5A5);
    step(1'b1, d, 1'b0, 1'b0);
    chk("slot0_new", 12544'(vector[12543:12528]), 12544'(16'hA5A5));

    // Tail chunk upper bits ignored.
    for (int k = 1; k < 12; k++) step(1'b1, rand_chunk(), 1'b0, 1'b0);
    d = '1;
    d[255:0] = {16{16'h0001}};
    step(1'b1, d, 1'b0, 1'b0);
    chk("tail_low_only", 12544'(vector[255:0]), 12544'({16{16'h0001}}));
    step(1'b0, '0, 1'b1, 1'b0);

    // Random valid gaps and random out_ready.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), rand_chunk(), 1'($urandom_range(0, 1)), 1'b0);

    // Drain to a clean COLLECT state with slot 0 next.
    guard = 0;
    while (m_full && guard < 5) begin step(1'b0, '0, 1'b1, 1'b0); guard++; end
    step(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset after 6 chunks.
    for (int k = 0; k < 6; k++) step(1'b1, rand_chunk(), 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    step(1'b1, rand_chunk(), 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    for (int k = 0; k < 13; k++) step(1'b1, rand_chunk(), 1'b0, 1'b0);
    chk("post_reset_full", 12544'(out_valid), 12544'(1'b1));
    step(1'b0, '0, 1'b1, 1'b0);

    // clr with a chunk presented after 4 chunks: dropped, everything zeroed.
    for (int k = 0; k < 4; k++) step(1'b1, rand_chunk(), 1'b0, 1'b0);
    step(1'b1, rand_chunk(), 1'b0, 1'b1);
    chk("clr_vector_zero", vector, '0);
    d = fill_chunk(16'h8000);
    step(1'b1, d, 1'b0, 1'b0);
    chk("clr_next_slot0", 12544'(vector[12543:12528]), 12544'(16'h8000));

    // clr together with out_ready while FULL.
    for (int k = 1; k < 13; k++) step(1'b1, rand_chunk(), 1'b0, 1'b0);
    step(1'b1, rand_chunk(), 1'b1, 1'b1);
    step(1'b1, rand_chunk(), 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
